// File: rtl/ifetch_stage_pkg.sv
// Shared fetch-stage types: word type, fetch FSM states and reset/bubble constants.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        e_ifetch_req,
        e_ifetch_wait,
        e_ifetch_hold
    } rvga_ifetch_state_e;

    localparam rvga_word RVGA_NOP_INSTR = 32'h0000_0013;
    localparam rvga_word RVGA_RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/ifetch_stage_if.sv
// Fetch-to-icache request/response handshake; master is the fetch stage, slave the icache.
interface ifetch_stage_if;
    import rvga_types::*;

    logic     ifetch_icache_req_v;
    rvga_word ifetch_icache_addr;
    logic     icache_ifetch_ready;
    logic     icache_ifetch_data_v;
    rvga_word icache_ifetch_data;

    modport master (
        output ifetch_icache_req_v,
        output ifetch_icache_addr,
        input  icache_ifetch_ready,
        input  icache_ifetch_data_v,
        input  icache_ifetch_data
    );

    modport slave (
        input  ifetch_icache_req_v,
        input  ifetch_icache_addr,
        output icache_ifetch_ready,
        output icache_ifetch_data_v,
        output icache_ifetch_data
    );
endinterface

// File: rtl/ifetch_stage_perf_cnt.sv
// Fetch performance counters (fetched / stall cycles / squashed responses), wrapping at 2^32.
module ifetch_perf_cnt
    import rvga_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     fetch_inc_i,
    input  logic     stall_inc_i,
    input  logic     squash_inc_i,
    output rvga_word fetched_o,
    output rvga_word stall_o,
    output rvga_word squash_o
);
    rvga_word fetched_q, stall_q, squash_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
            squash_q  <= '0;
        end else begin
            if (fetch_inc_i)  fetched_q <= fetched_q + 32'd1;
            if (stall_inc_i)  stall_q   <= stall_q + 32'd1;
            if (squash_inc_i) squash_q  <= squash_q + 32'd1;
        end
    end

    assign fetched_o = fetched_q;
    assign stall_o   = stall_q;
    assign squash_o  = squash_q;
endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: single-outstanding icache fetch, stall hold buffer, redirect squash.
// Optional counters are built when IFETCH_PERF_CNT_EN is defined.
module ifetch_stage
    import rvga_types::*;
#(
    parameter rvga_word RESET_PC  = RVGA_RESET_PC,
    parameter rvga_word NOP_INSTR = RVGA_NOP_INSTR
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_stage_if.master icache,
    input  logic           stall_i,
    input  logic           redirect_v_i,
    input  rvga_word       redirect_pc_i,
    output rvga_word       ifetch_decode_pc,
    output rvga_word       ifetch_decode_instruction
`ifdef IFETCH_PERF_CNT_EN
    ,
    output rvga_word       ifetch_perf_fetched,
    output rvga_word       ifetch_perf_stall,
    output rvga_word       ifetch_perf_squash
`endif
);
    rvga_ifetch_state_e state_q;
    rvga_word pc_q, req_pc_q, hold_pc_q, hold_instr_q, dec_pc_q, dec_instr_q;
    logic     squash_q, req_v_q;
    logic     accept, outstanding;

    assign accept = req_v_q & icache.icache_ifetch_ready;
    // A response is still owed unless it is arriving right now.
    assign outstanding = ((state_q == e_ifetch_wait) && !icache.icache_ifetch_data_v) || accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= e_ifetch_req;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= NOP_INSTR;
            dec_pc_q     <= '0;
            dec_instr_q  <= NOP_INSTR;
            squash_q     <= 1'b0;
            req_v_q      <= 1'b0;
        end else if (redirect_v_i) begin
            pc_q        <= redirect_pc_i & ~32'h3;
            dec_pc_q    <= '0;
            dec_instr_q <= NOP_INSTR;
            if (accept) req_pc_q <= pc_q;
            if (outstanding) begin
                state_q  <= e_ifetch_wait;
                squash_q <= 1'b1;
                req_v_q  <= 1'b0;
            end else begin
                state_q  <= e_ifetch_req;
                squash_q <= 1'b0;
                req_v_q  <= 1'b1;
            end
        end else begin
            if (!stall_i) begin
                dec_pc_q    <= '0;
                dec_instr_q <= NOP_INSTR;
            end
            case (state_q)
                e_ifetch_req: begin
                    if (accept) begin
                        pc_q     <= pc_q + 32'd4;
                        req_pc_q <= pc_q;
                        state_q  <= e_ifetch_wait;
                        req_v_q  <= 1'b0;
                    end else begin
                        req_v_q  <= 1'b1;
                    end
                end
                e_ifetch_wait: begin
                    if (icache.icache_ifetch_data_v) begin
                        if (squash_q) begin
                            squash_q <= 1'b0;
                            state_q  <= e_ifetch_req;
                            req_v_q  <= 1'b1;
                        end else if (!stall_i) begin
                            dec_pc_q    <= req_pc_q;
                            dec_instr_q <= icache.icache_ifetch_data;
                            state_q     <= e_ifetch_req;
                            req_v_q     <= 1'b1;
                        end else begin
                            hold_pc_q    <= req_pc_q;
                            hold_instr_q <= icache.icache_ifetch_data;
                            state_q      <= e_ifetch_hold;
                        end
                    end
                end
                e_ifetch_hold: begin
                    if (!stall_i) begin
                        dec_pc_q    <= hold_pc_q;
                        dec_instr_q <= hold_instr_q;
                        state_q     <= e_ifetch_req;
                        req_v_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= e_ifetch_req;
                    req_v_q <= 1'b1;
                end
            endcase
        end
    end

    assign icache.ifetch_icache_req_v = req_v_q;
    assign icache.ifetch_icache_addr  = pc_q;
    assign ifetch_decode_pc           = dec_pc_q;
    assign ifetch_decode_instruction  = dec_instr_q;

    // The icache only answers an accepted request, so data outside WAIT is a protocol error.
    assert property (@(posedge clk) disable iff (!rst)
        icache.icache_ifetch_data_v |-> (state_q == e_ifetch_wait));

`ifdef IFETCH_PERF_CNT_EN
    logic load_now, drop_now;
    assign load_now = !redirect_v_i && !stall_i &&
                      (((state_q == e_ifetch_wait) && icache.icache_ifetch_data_v && !squash_q) ||
                       (state_q == e_ifetch_hold));
    assign drop_now = (state_q == e_ifetch_wait) && icache.icache_ifetch_data_v &&
                      (squash_q || redirect_v_i);

    ifetch_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst          (rst),
        .fetch_inc_i  (load_now),
        .stall_inc_i  (stall_i),
        .squash_inc_i (drop_now),
        .fetched_o    (ifetch_perf_fetched),
        .stall_o      (ifetch_perf_stall),
        .squash_o     (ifetch_perf_squash)
    );
`endif
endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: directed fetch/stall/redirect/wrap vectors, monitor-side checking.
module tb_ifetch_stage;
    import rvga_types::*;

    logic     clk = 1'b0;
    logic     rst = 1'b0;
    logic     stall_i = 1'b0;
    logic     redirect_v_i = 1'b0;
    rvga_word redirect_pc_i = '0;
    rvga_word dec_pc, dec_instr;
`ifdef IFETCH_PERF_CNT_EN
    rvga_word perf_fetched, perf_stall, perf_squash;
`endif

    always #5 clk = ~clk;

    ifetch_stage_if ifc();

    ifetch_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .icache                    (ifc),
        .stall_i                   (stall_i),
        .redirect_v_i              (redirect_v_i),
        .redirect_pc_i             (redirect_pc_i),
        .ifetch_decode_pc          (dec_pc),
        .ifetch_decode_instruction (dec_instr)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .ifetch_perf_fetched       (perf_fetched),
        .ifetch_perf_stall         (perf_stall),
        .ifetch_perf_squash        (perf_squash)
`endif
    );

    int errors = 0;
    int checks = 0;
    int resp_lat = 1;
    int stall_cycles = 0;
    int n_fetched = 0;
    rvga_word    exp_addr_q[$];
    rvga_word    resp_q[$];
    logic [63:0] exp_out_q[$];

    task automatic check(input string name, input rvga_word act, input rvga_word exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input rvga_word pc, input rvga_word instr);
        exp_out_q.push_back({pc, instr});
        n_fetched++;
    endtask

    // Wait for a request, accept it for one cycle, and queue its response word.
    task automatic do_fetch(input rvga_word addr, input rvga_word word);
        int n;
        n = 0;
        exp_addr_q.push_back(addr);
        resp_q.push_back(word);
        while (ifc.ifetch_icache_req_v !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL req_wait: req_v=%b after %0d cycles, required 1", ifc.ifetch_icache_req_v, n);
        end
        ifc.icache_ifetch_ready = 1'b1;
        tick();
        ifc.icache_ifetch_ready = 1'b0;
    endtask

    // icache model: one response resp_lat cycles after each accepted request.
    initial begin
        ifc.icache_ifetch_data_v = 1'b0;
        ifc.icache_ifetch_data   = '0;
        forever begin
            @(posedge clk);
            if (rst && ifc.ifetch_icache_req_v && ifc.icache_ifetch_ready) begin
                int       lat;
                rvga_word w;
                lat = resp_lat;
                w = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hDEAD_BEEF;
                repeat (lat - 1) @(posedge clk);
                #1;
                ifc.icache_ifetch_data_v = 1'b1;
                ifc.icache_ifetch_data   = w;
                @(posedge clk);
                #1;
                ifc.icache_ifetch_data_v = 1'b0;
            end
        end
    end

    // Monitor: request addresses and decode outputs against the scoreboard queues.
    initial begin
        logic        st;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            st = stall_i;
            if (rst && stall_i) stall_cycles++;
            if (rst && ifc.ifetch_icache_req_v && ifc.icache_ifetch_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_addr: unexpected request addr=%h, required none", ifc.ifetch_icache_addr);
                end else begin
                    check("req_addr", ifc.ifetch_icache_addr, exp_addr_q.pop_front());
                end
            end
            #2;
            if (rst) begin
                if (dec_instr == RVGA_NOP_INSTR) begin
                    check("bubble_pc", dec_pc, 32'h0);
                end else if (!st) begin
                    if (exp_out_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dec_out: unexpected pc=%h instr=%h, required bubble", dec_pc, dec_instr);
                    end else begin
                        e = exp_out_q.pop_front();
                        $display("decode pc=%h instr=%h", dec_pc, dec_instr);
                        check("dec_pc", dec_pc, e[63:32]);
                        check("dec_instr", dec_instr, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.icache_ifetch_ready = 1'b0;
        repeat (3) tick();
        check("rst_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, RVGA_NOP_INSTR);
        rst = 1'b1;

        // Basic fetch from reset PC.
        expect_out(32'h0, 32'h0050_0093);
        do_fetch(32'h0, 32'h0050_0093);
        tick();
        check("t1_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h1);
        check("t1_next_addr", ifc.ifetch_icache_addr, 32'h4);

        // Response lands while stalled: outputs hold, word parks in HOLD.
        stall_i = 1'b1;
        do_fetch(32'h4, 32'hAAAA_AAAA);
        tick();
        tick();
        check("t2_hold_pc", dec_pc, 32'h0);
        check("t2_hold_instr", dec_instr, 32'h0050_0093);
        check("t2_hold_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h0);
        expect_out(32'h4, 32'hAAAA_AAAA);
        stall_i = 1'b0;
        tick();
        check("t2_resume_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h1);
        check("t2_resume_addr", ifc.ifetch_icache_addr, 32'h8);

        // Redirect while the request is outstanding: response dropped.
        resp_lat = 3;
        do_fetch(32'h8, 32'h1111_1111);
        resp_lat = 1;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h0000_1002;
        tick();
        redirect_v_i = 1'b0;
        check("t3_wait_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h0);
        check("t3_dec_instr", dec_instr, RVGA_NOP_INSTR);
        tick();
        check("t3_still_wait", {31'b0, ifc.ifetch_icache_req_v}, 32'h0);
        tick();
        check("t3_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h1);
        check("t3_addr", ifc.ifetch_icache_addr, 32'h0000_1000);
        expect_out(32'h0000_1000, 32'h0010_0113);
        do_fetch(32'h0000_1000, 32'h0010_0113);
        tick();
        tick();

        // Redirect in REQ without ready, then address stability while not ready.
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h0000_0008;
        tick();
        redirect_v_i = 1'b0;
        check("t4_redir_addr", ifc.ifetch_icache_addr, 32'h8);
        check("t4_redir_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h1);
        tick();
        tick();
        check("t4_stable_addr", ifc.ifetch_icache_addr, 32'h8);

        // Redirect coincident with accept at pc=8: that response is squashed.
        exp_addr_q.push_back(32'h8);
        resp_q.push_back(32'h2222_2222);
        ifc.icache_ifetch_ready = 1'b1;
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'h0000_2000;
        tick();
        ifc.icache_ifetch_ready = 1'b0;
        redirect_v_i = 1'b0;
        check("t4_squash_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h0);
        tick();
        check("t4_after_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h1);
        check("t4_after_addr", ifc.ifetch_icache_addr, 32'h0000_2000);
        expect_out(32'h0000_2000, 32'h3333_3333);
        do_fetch(32'h0000_2000, 32'h3333_3333);
        tick();
        tick();

        // PC wrap at the top of the address space.
        redirect_v_i  = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_v_i = 1'b0;
        expect_out(32'hFFFF_FFFC, 32'h4444_4444);
        do_fetch(32'hFFFF_FFFC, 32'h4444_4444);
        tick();
        check("t5_wrap_addr", ifc.ifetch_icache_addr, 32'h0);
        expect_out(32'h0, 32'h5555_5555);
        do_fetch(32'h0, 32'h5555_5555);
        tick();
        tick();

        check("end_out_queue", exp_out_q.size(), 32'h0);
        check("end_addr_queue", exp_addr_q.size(), 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, n_fetched);
        check("perf_stall", perf_stall, stall_cycles);
        check("perf_squash", perf_squash, 32'd2);
`endif

        // Asynchronous reset mid-cycle while a request is pending.
        check("pre_rst_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req_v", {31'b0, ifc.ifetch_icache_req_v}, 32'h0);
        check("async_rst_addr", ifc.ifetch_icache_addr, RVGA_RESET_PC);
        check("async_rst_instr", dec_instr, RVGA_NOP_INSTR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
